// File: rtl/arith_pkg.sv
// Shared arithmetic constants, FSM state encoding and sizing helper.
package arith_pkg;

  localparam int BLK_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/skip_block_slice.sv
// One 4-bit ripple slice with a carry-skip bypass.
module skip_block_slice
  import arith_pkg::*;
(
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             cin,
  output logic [BLK_W-1:0] s,
  output logic             cout,
  output logic             skip
);

  logic [BLK_W-1:0] p;
  logic [BLK_W:0]   c;

  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar i = 0; i < BLK_W; i++) begin : g_bit
    assign s[i]   = p[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
  end

  assign skip = &p;
  assign cout = skip ? cin : c[BLK_W];

endmodule

// File: rtl/block_serial_subtractor.sv
// Block-serial signed subtractor D = A - B, one 4-bit block per clock.
// Optional SUB_SATURATE_EN clamps D on signed overflow.
module block_serial_subtractor
  import arith_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [N-1:0]                      A,
  input  logic [N-1:0]                      B,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N-1:0]                      D,
  output logic                              borrow,
  output logic                              overflow,
  output logic [clog2(N/BLK_W+1)-1:0]       skip_cnt
);

  localparam int NBLK = N / BLK_W;
  localparam int IW   = clog2(NBLK);
  localparam int SW   = clog2(NBLK + 1);

  typedef logic [NBLK-1:0][BLK_W-1:0] blk_vec_t;

  state_t           state, state_n;
  blk_vec_t         a_q, bn_q, d_q, d_n;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [SW-1:0]    skip_q;
  logic             borrow_q, ovf_q;

  logic [BLK_W-1:0] s;
  logic             cout, skip;
  logic             last, a_sign, ovf_n;

  skip_block_slice u_slice (
    .a    (a_q[idx_q]),
    .b    (bn_q[idx_q]),
    .cin  (carry_q),
    .s    (s),
    .cout (cout),
    .skip (skip)
  );

  assign last   = (idx_q == IW'(NBLK - 1));
  assign a_sign = a_q[NBLK-1][BLK_W-1];

  // B's sign is the inverse of the stored ~B sign bit
  assign ovf_n = (a_sign == bn_q[NBLK-1][BLK_W-1])
              && (s[BLK_W-1] != a_sign);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    d_n = d_q;
    d_n[idx_q] = s;
`ifdef SUB_SATURATE_EN
    if (last && ovf_n)
      d_n = a_sign ? {1'b1, {(N-1){1'b0}}}
                   : {1'b0, {(N-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      bn_q     <= '0;
      d_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      skip_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            bn_q    <= ~B;
            carry_q <= 1'b1;
            idx_q   <= '0;
            skip_q  <= '0;
          end
        end
        RUN: begin
          d_q     <= d_n;
          carry_q <= cout;
          idx_q   <= idx_q + IW'(1);
          skip_q  <= skip_q + SW'(skip);
          if (last) begin
            borrow_q <= ~cout;
            ovf_q    <= ovf_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign D         = d_q;
  assign borrow    = borrow_q;
  assign overflow  = ovf_q;
  assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Scoreboard bench for block_serial_subtractor (N=32).
// Build with +define+SUB_SATURATE_EN to check the saturating variant.
module tb_block_serial_subtractor;

  localparam int N    = 32;
  localparam int NBLK = 8;
  localparam int SW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_ready;
  logic          out_valid, out_ready;
  logic [N-1:0]  A, B, D;
  logic          borrow, overflow;
  logic [SW-1:0] skip_cnt;

  always #5 clk = ~clk;

  block_serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .borrow    (borrow),
    .overflow  (overflow),
    .skip_cnt  (skip_cnt)
  );

  typedef struct packed {
    logic [N-1:0]  d;
    logic          borrow;
    logic          ovf;
    logic [SW-1:0] skip;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [N-1:0] a,
                                 input logic [N-1:0] b);
    exp_t e;
    int   k;
    e.d      = a - b;
    e.borrow = (a < b);
    e.ovf    = (a[N-1] != b[N-1]) && (e.d[N-1] != a[N-1]);
    // a block is skipped when A's nibble equals B's nibble
    k = 0;
    for (int i = 0; i < NBLK; i++)
      if (a[i*4 +: 4] == b[i*4 +: 4]) k++;
    e.skip = SW'(k);
`ifdef SUB_SATURATE_EN
    if (e.ovf)
      e.d = a[N-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return e;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got D=%0h expected none", D);
      end else begin
        mon_e = q.pop_front();
        check("D", D, mon_e.d);
        check("borrow", borrow, mon_e.borrow);
        check("overflow", overflow, mon_e.ovf);
        check("skip_cnt", skip_cnt, mon_e.skip);
      end
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic op(input logic [N-1:0] a,
                    input logic [N-1:0] b,
                    input int stall,
                    input bit pulse);
    exp_t e;
    int   lat;
    e = model(a, b);
    q.push_back(e);
    out_ready = (stall == 0);
    wait_ready();
    in_valid = 1'b1;
    A = a;
    B = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    // the accept edge is counted as edge 1
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, NBLK + 1);
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        in_valid = (i % 2 == 0);
        A = ~a;
        B = $urandom;
      end
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_D", D, e.d);
      check("hold_borrow", borrow, e.borrow);
      check("hold_overflow", overflow, e.ovf);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_flags", {borrow, overflow, skip_cnt}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    op(32'd10, 32'd3, 0, 0);
    op(32'd3, 32'd10, 0, 0);
    op(32'h8000_0000, 32'd1, 0, 0);
    op(32'h0F0F_0F0F, 32'h0F0F_0F0F, 0, 0);
    op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    op(32'h1234_0005, 32'h0000_0009, 5, 1);
    op(32'hDEAD_BEEF, 32'h1234_5678, 0, 0);

    out_ready = 1'b1;
    wait_ready();
    in_valid = 1'b1;
    A = 32'h1234_5678;
    B = 32'h0101_0101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_D", D, 0);
    check("abort_flags", {borrow, overflow, skip_cnt}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    op(32'd100, -32'sd28, 0, 0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1)
        rb = ra ^ ($urandom & 32'h0F0F_F00F);
      else
        rb = $urandom;
      op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
